// File: rtl/rca_config_unit_pkg.sv
// rca_config_unit_pkg: sizing constants, command type and per-RCA table layout
package rca_config_unit_pkg;
    localparam int NUM_RCAS = 2;
    localparam int NUM_READ_PORTS = 5;
    localparam int NUM_WRITE_PORTS = 2;
    localparam int NUM_GRID_MUXES = 32;
    localparam int GRID_MUX_INPUTS = 8;
    localparam int GRID_NUM_ROWS = 4;
    localparam int IO_UNIT_MUX_INPUTS = 8;
    localparam int REG_W = 5;
    localparam int ID_W = 4;
    localparam int RCA_W = $clog2(NUM_RCAS);
    localparam int RP_W = $clog2(NUM_READ_PORTS);
    localparam int WP_W = $clog2(NUM_WRITE_PORTS);
    localparam int GM_W = $clog2(NUM_GRID_MUXES);
    localparam int IOA_W = $clog2(GRID_NUM_ROWS);
    localparam int GRID_SEL_W = $clog2(GRID_MUX_INPUTS);
    localparam int IO_SEL_W = $clog2(IO_UNIT_MUX_INPUTS);
    localparam int RES_SEL_W = $clog2(GRID_NUM_ROWS);
    localparam int WR_ADDR_W = GM_W;
    localparam int WR_DATA_W = REG_W;

    typedef enum logic [1:0] {CMD_CPU, CMD_GRID, CMD_IO, CMD_RESULT} rca_config_cmd_type_t;

    typedef struct packed {
        logic [NUM_READ_PORTS-1:0][REG_W-1:0] src;
        logic [NUM_WRITE_PORTS-1:0][REG_W-1:0] dest;
        logic [NUM_GRID_MUXES-1:0][GRID_SEL_W-1:0] grid;
        logic [GRID_NUM_ROWS-1:0][IO_SEL_W-1:0] io;
        logic [NUM_WRITE_PORTS-1:0][RES_SEL_W-1:0] res;
    } rca_table_t;
endpackage

// File: rtl/taiga_types.sv
// taiga_types: command and CPU-register config types shared with decode/issue
package taiga_types;
    import rca_config_unit_pkg::*;

    typedef logic [ID_W-1:0] id_t;

    typedef struct packed {
        logic [NUM_READ_PORTS-1:0][REG_W-1:0] rs_addr;
        logic [NUM_WRITE_PORTS-1:0][REG_W-1:0] rd_addr;
    } rca_config_t;

    typedef struct packed {
        logic rca_cpu_reg_config;
        logic rca_grid_config;
        logic rca_io_config;
        logic rca_result_config;
        logic [1:0] rca_sel;
        logic cpu_src_dest_port;
        logic [2:0] cpu_port_sel;
        logic [4:0] cpu_reg_addr;
        logic [5:0] grid_mux_addr;
        logic [2:0] new_grid_mux_sel;
        logic [2:0] io_mux_addr;
        logic [2:0] new_io_mux_sel;
        logic [1:0] rca_result_mux_addr;
        logic [1:0] new_rca_result_mux_sel;
    } rca_inputs_t;
endpackage

// File: rtl/rca_config_table.sv
// rca_config_table: configuration storage of one RCA, one write port, full read-out
module rca_config_table
    import rca_config_unit_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic wr_en,
    input  rca_config_cmd_type_t wr_type,
    input  logic wr_dest,
    input  logic [WR_ADDR_W-1:0] wr_addr,
    input  logic [WR_DATA_W-1:0] wr_data,
    output rca_table_t tbl
);
    rca_table_t tbl_q, tbl_d;

    assign tbl = tbl_q;

    // Update the single addressed entry of the selected table
    always_comb begin
        tbl_d = tbl_q;
        if (wr_en) begin
            if (wr_type == CMD_CPU && wr_dest) tbl_d.dest[wr_addr[WP_W-1:0]] = wr_data;
            else if (wr_type == CMD_CPU) tbl_d.src[wr_addr[RP_W-1:0]] = wr_data;
            else if (wr_type == CMD_GRID) tbl_d.grid[wr_addr[GM_W-1:0]] = wr_data[GRID_SEL_W-1:0];
            else if (wr_type == CMD_IO) tbl_d.io[wr_addr[IOA_W-1:0]] = wr_data[IO_SEL_W-1:0];
            else tbl_d.res[wr_addr[WP_W-1:0]] = wr_data[RES_SEL_W-1:0];
        end
    end

    // Table register, cleared on reset
    always_ff @(posedge clk) begin
        if (rst) tbl_q <= '0;
        else tbl_q <= tbl_d;
    end
endmodule

// File: rtl/rca_config_unit.sv
// rca_config_unit: accepts RCA config commands, holds per-RCA tables, reports completion
module rca_config_unit
    import rca_config_unit_pkg::*, taiga_types::*;
(
    input  logic clk,
    input  logic rst,
    input  logic new_request,
    output logic ready,
    input  rca_inputs_t cmd,
    input  id_t cmd_id,
    input  logic [NUM_RCAS-1:0] rca_busy,
    output logic done,
    output id_t done_id,
    output logic done_err,
    input  logic done_ack,
    input  logic [RCA_W-1:0] query_sel,
    output rca_config_t query_cfg,
    output logic [NUM_GRID_MUXES-1:0][GRID_SEL_W-1:0] query_grid_sels,
    output logic [GRID_NUM_ROWS-1:0][IO_SEL_W-1:0] query_io_sels,
    output logic [NUM_WRITE_PORTS-1:0][RES_SEL_W-1:0] query_result_sels
);
    typedef enum logic [1:0] {ST_IDLE, ST_PENDING, ST_DONE} state_t;

    state_t state_q, state_d;
    logic ready_q, ready_d, done_q, done_d, err_q, err_d;
    id_t id_q, id_d;
    rca_inputs_t cmd_q, cmd_d;
    logic [3:0] flags;
    logic malformed, wr_en;
    rca_config_cmd_type_t cmd_type;
    logic [WR_ADDR_W-1:0] wr_addr;
    logic [WR_DATA_W-1:0] wr_data;
    rca_table_t tbls [2**RCA_W];
    rca_table_t q;

    assign ready = ready_q;
    assign done = done_q;
    assign done_id = id_q;
    assign done_err = err_q;

    // Decode the latched command: type, validity and the entry to write
    always_comb begin
        flags = {cmd_q.rca_cpu_reg_config, cmd_q.rca_grid_config, cmd_q.rca_io_config, cmd_q.rca_result_config};
        cmd_type = flags[3] ? CMD_CPU : flags[2] ? CMD_GRID : flags[1] ? CMD_IO : CMD_RESULT;
        malformed = !$onehot(flags) || cmd_q.rca_sel >= 2'(NUM_RCAS) ||
            (cmd_type == CMD_CPU && cmd_q.cpu_src_dest_port && cmd_q.cpu_port_sel >= 3'(NUM_WRITE_PORTS)) ||
            (cmd_type == CMD_CPU && !cmd_q.cpu_src_dest_port && cmd_q.cpu_port_sel >= 3'(NUM_READ_PORTS)) ||
            (cmd_type == CMD_GRID && cmd_q.grid_mux_addr >= 6'(NUM_GRID_MUXES)) ||
            (cmd_type == CMD_IO && cmd_q.io_mux_addr >= 3'(GRID_NUM_ROWS)) ||
            (cmd_type == CMD_RESULT && cmd_q.rca_result_mux_addr >= 2'(NUM_WRITE_PORTS));
        wr_addr = cmd_type == CMD_CPU ? WR_ADDR_W'(cmd_q.cpu_port_sel) :
                  cmd_type == CMD_GRID ? cmd_q.grid_mux_addr[GM_W-1:0] :
                  cmd_type == CMD_IO ? WR_ADDR_W'(cmd_q.io_mux_addr[IOA_W-1:0]) :
                  WR_ADDR_W'(cmd_q.rca_result_mux_addr[WP_W-1:0]);
        wr_data = cmd_type == CMD_CPU ? cmd_q.cpu_reg_addr :
                  cmd_type == CMD_GRID ? WR_DATA_W'(cmd_q.new_grid_mux_sel) :
                  cmd_type == CMD_IO ? WR_DATA_W'(cmd_q.new_io_mux_sel) :
                  WR_DATA_W'(cmd_q.new_rca_result_mux_sel);
    end

    // Handshake FSM next state; a busy RCA holds a valid command in PENDING
    always_comb begin
        state_d = state_q;
        ready_d = ready_q;
        done_d = done_q;
        err_d = err_q;
        id_d = id_q;
        cmd_d = cmd_q;
        wr_en = 1'b0;
        if (state_q == ST_IDLE && new_request) begin
            cmd_d = cmd;
            id_d = cmd_id;
            ready_d = 1'b0;
            state_d = ST_PENDING;
        end else if (state_q == ST_PENDING && (malformed || !rca_busy[cmd_q.rca_sel[RCA_W-1:0]])) begin
            wr_en = !malformed;
            err_d = malformed;
            done_d = 1'b1;
            state_d = ST_DONE;
        end else if (state_q == ST_DONE && done_ack) begin
            done_d = 1'b0;
            err_d = 1'b0;
            ready_d = 1'b1;
            state_d = ST_IDLE;
        end
    end

    // FSM state and registered handshake outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b1;
            done_q <= 1'b0;
            err_q <= 1'b0;
            id_q <= '0;
            cmd_q <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            done_q <= done_d;
            err_q <= err_d;
            id_q <= id_d;
            cmd_q <= cmd_d;
        end
    end

    for (genvar i = 0; i < 2**RCA_W; i++) begin : g_rca
        if (i < NUM_RCAS) begin : g_tbl
            rca_config_table u_tbl (
                .clk(clk),
                .rst(rst),
                .wr_en(wr_en && cmd_q.rca_sel == 2'(i)),
                .wr_type(cmd_type),
                .wr_dest(cmd_q.cpu_src_dest_port),
                .wr_addr(wr_addr),
                .wr_data(wr_data),
                .tbl(tbls[i])
            );
        end else begin : g_none
            assign tbls[i] = '0;
        end
    end

    assign q = tbls[query_sel];
    assign query_cfg = {q.src, q.dest};
    assign query_grid_sels = q.grid;
    assign query_io_sels = q.io;
    assign query_result_sels = q.res;
endmodule
